// File: rtl/draw_game_multi_if.sv
// Raster timing bundle shared by the VGA pipeline.
// The renderer only consumes hcount/vcount.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;

    modport in  (input  hcount, input  vcount);
    modport out (output hcount, output vcount);
endinterface

// File: rtl/draw_game_multi.sv
// Bird + N_TUBES pipe renderer with game-phase FSM and score.
// Optional HIT_FLASH_EN: bird flashes red/blue every 8 frames in HIT.
module draw_game_multi #(
    parameter int N_TUBES      = 3,
    parameter int H_ACTIVE     = 1024,
    parameter int BIRD_X       = 200,
    parameter int BIRD_W       = 40,
    parameter int BIRD_H       = 50,
    parameter int TUBE_W       = 120,
    parameter int GAP_H        = 400,
    parameter int START_FRAMES = 60,
    parameter int SCORE_W      = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   game_rst,
    vga_if.in                      vin,
    input  logic [10:0]            bird_y,
    input  logic                   bird_col,
    input  logic [N_TUBES*11-1:0]  tube_x,
    input  logic [N_TUBES*11-1:0]  gap_y,
    output logic [11:0]            rgb,
    output logic                   valid,
    output logic                   collision,
    output logic [SCORE_W-1:0]     score,
    output logic [1:0]             phase
);

    typedef enum logic [1:0] {
        ARMING  = 2'd0,
        RUNNING = 2'd1,
        HIT     = 2'd2
    } phase_t;

    localparam int CW = $clog2(START_FRAMES) + 1;
    localparam logic [CW-1:0] LAST_F = CW'(START_FRAMES - 1);
    localparam logic [11:0] BX0 = 12'(BIRD_X);
    localparam logic [11:0] BX1 = 12'(BIRD_X + BIRD_W);
    localparam logic [11:0] BH  = 12'(BIRD_H);
    localparam logic [11:0] TW  = 12'(TUBE_W);
    localparam logic [11:0] GH  = 12'(GAP_H);
    localparam logic [11:0] HA  = 12'(H_ACTIVE);
    localparam logic [SCORE_W+3:0] SMAX = {4'd0, {SCORE_W{1'b1}}};

    phase_t state_q, state_d;
    logic [CW-1:0] frame_cnt;
    logic [N_TUBES-1:0][11:0] prev_e;
    logic [N_TUBES-1:0][11:0] tube_e;
    logic [N_TUBES-1:0][11:0] rel;
    logic [N_TUBES-1:0] tube_hit;
    logic [N_TUBES-1:0] pass;

    logic [11:0] h12, v12, by12;
    logic frame_start, bird_hit, tube_any;
    logic [11:0] tube_rgb, bird_rgb;
    logic [3:0] n_pass;
    logic [SCORE_W+3:0] score_sum;

    assign h12  = {1'b0, vin.hcount};
    assign v12  = {1'b0, vin.vcount};
    assign by12 = {1'b0, bird_y};
    assign frame_start = (vin.hcount == 11'd0) && (vin.vcount == 11'd0);
    assign phase = state_q;

    assign bird_hit = (h12 >= BX0) && (h12 < BX1) &&
                      (v12 >= by12) && (v12 < by12 + BH);

    for (genvar g = 0; g < N_TUBES; g++) begin : g_tube
        logic [11:0] tx, gy;
        assign tx = {1'b0, tube_x[g*11 +: 11]};
        assign gy = {1'b0, gap_y[g*11 +: 11]};
        assign tube_e[g] = tx + TW;
        assign rel[g] = h12 - tx;
        assign tube_hit[g] = (state_q != ARMING) && (tx < HA) &&
                             (h12 >= tx) && (h12 < tube_e[g]) &&
                             ((v12 < gy) || (v12 > gy + GH));
        assign pass[g] = (prev_e[g] >= BX0) && (tube_e[g] < BX0);
    end

    assign tube_any = |tube_hit;

    function automatic logic [11:0] tube_col(input logic [11:0] r);
        if (r < 12'd5 || r >= TW - 12'd5) return 12'h000;
        else if (r < 12'd20)              return 12'h0F0;
        else if (r < 12'd40)              return 12'h0C0;
        else if (r < 12'd80)              return 12'h090;
        else                              return 12'h0D0;
    endfunction

    // Tube colour: scan downwards so the lowest-index hit is applied last
    always_comb begin
        tube_rgb = 12'h000;
        for (int i = N_TUBES - 1; i >= 0; i--) begin
            if (tube_hit[i]) tube_rgb = tube_col(rel[i]);
        end
    end

    // Number of tubes whose right edge crossed the bird this frame
    always_comb begin
        n_pass = 4'd0;
        for (int i = 0; i < N_TUBES; i++) begin
            n_pass = n_pass + 4'(pass[i]);
        end
        score_sum = {4'd0, score} + (SCORE_W+4)'(n_pass);
    end

`ifdef HIT_FLASH_EN
    logic [3:0] flash_cnt;

    // Free-running frame counter driving the HIT flash
    always_ff @(posedge clk) begin
        if (rst) flash_cnt <= 4'd0;
        else if (frame_start) flash_cnt <= flash_cnt + 4'd1;
    end

    assign bird_rgb = (state_q == HIT && flash_cnt[3]) ? 12'hF00 : 12'h00F;
`else
    assign bird_rgb = 12'h00F;
`endif

    // Phase transitions; restart handled in the register
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARMING: begin
                if (bird_col)
                    state_d = HIT;
                else if (frame_start && frame_cnt == LAST_F)
                    state_d = RUNNING;
            end
            RUNNING: begin
                if (bird_col || (bird_hit && tube_any))
                    state_d = HIT;
            end
            HIT:     state_d = HIT;
            default: state_d = ARMING;
        endcase
    end

    // State, pixel output, collision flag, score and edge history
    always_ff @(posedge clk) begin
        if (rst || game_rst) begin
            state_q   <= ARMING;
            frame_cnt <= '0;
            rgb       <= 12'h000;
            valid     <= 1'b0;
            collision <= 1'b0;
            score     <= '0;
            prev_e    <= '0;
        end else begin
            state_q   <= state_d;
            valid     <= bird_hit || tube_any;
            rgb       <= bird_hit ? bird_rgb :
                         tube_any ? tube_rgb : 12'h000;
            collision <= collision || (state_q == HIT);
            if (frame_start) begin
                prev_e <= tube_e;
                if (state_q == ARMING && frame_cnt != LAST_F)
                    frame_cnt <= frame_cnt + 1'b1;
                if (state_q == RUNNING)
                    score <= (score_sum > SMAX) ? {SCORE_W{1'b1}}
                                                : score_sum[SCORE_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_draw_game_multi.sv
// Directed bench for draw_game_multi (START_FRAMES=4, 3 tubes).
// Raster is driven pixel by pixel; (0,0) marks a frame start.
module tb_draw_game_multi;

    logic clk = 1'b0;
    logic rst, game_rst, bird_col;
    logic [10:0] bird_y;
    logic [32:0] tube_x, gap_y;
    logic [11:0] rgb;
    logic valid, collision;
    logic [7:0] score;
    logic [1:0] phase;
    int n_chk = 0;
    int n_fail = 0;

    vga_if vif();

    draw_game_multi #(.START_FRAMES(4)) dut (
        .clk(clk), .rst(rst), .game_rst(game_rst), .vin(vif),
        .bird_y(bird_y), .bird_col(bird_col),
        .tube_x(tube_x), .gap_y(gap_y),
        .rgb(rgb), .valid(valid), .collision(collision),
        .score(score), .phase(phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int h, input int v);
        vif.hcount = 11'(h);
        vif.vcount = 11'(v);
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        cyc(0, 0);
        cyc(1000, 767);
    endtask

    task automatic set_tube(input int i, input int x, input int g);
        tube_x[i*11 +: 11] = 11'(x);
        gap_y[i*11 +: 11]  = 11'(g);
    endtask

    initial begin
        logic [11:0] c0;
        rst = 1'b1; game_rst = 1'b0; bird_col = 1'b0;
        bird_y = 11'd600;
        set_tube(0, 1100, 100);
        set_tube(1, 1100, 100);
        set_tube(2, 1100, 100);
        cyc(1000, 767);
        cyc(1000, 767);
        rst = 1'b0;
        chk("rst_phase", 32'(phase), 0);
        chk("rst_coll", 32'(collision), 0);
        chk("rst_score", 32'(score), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_rgb", 32'(rgb), 0);

        set_tube(0, 300, 100);
        for (int f = 0; f < 4; f++) begin
            cyc(310, 50);
            chk("arm_valid", 32'(valid), 0);
            chk("arm_phase", 32'(phase), 0);
            frame();
        end
        chk("run_phase", 32'(phase), 1);
        cyc(310, 50);
        chk("run_valid", 32'(valid), 1);
        chk("rel10", 32'(rgb), 32'h0F0);
        cyc(300, 50);  chk("rel0", 32'(rgb), 32'h000);
        cyc(330, 50);  chk("rel30", 32'(rgb), 32'h0C0);
        cyc(370, 50);  chk("rel70", 32'(rgb), 32'h090);
        cyc(400, 50);  chk("rel100", 32'(rgb), 32'h0D0);
        cyc(419, 50);  chk("rel119", 32'(rgb), 32'h000);
        cyc(420, 50);  chk("right_out", 32'(valid), 0);
        cyc(310, 99);  chk("above_gap", 32'(rgb), 32'h0F0);
        cyc(310, 100); chk("gap_top", 32'(valid), 0);
        cyc(310, 500); chk("gap_bot", 32'(valid), 0);
        cyc(310, 501); chk("below_gap", 32'(rgb), 32'h0F0);
        cyc(1150, 10); chk("offscreen", 32'(valid), 0);

        bird_y = 11'd60;
        cyc(200, 60);  chk("bird_tl", 32'(rgb), 32'h00F);
        cyc(239, 109); chk("bird_br", 32'(rgb), 32'h00F);
        cyc(240, 60);  chk("bird_r", 32'(valid), 0);
        cyc(200, 110); chk("bird_b", 32'(valid), 0);
        cyc(200, 59);  chk("bird_t", 32'(valid), 0);
        chk("bird_nohit", 32'(phase), 1);

        set_tube(1, 81, 100);
        frame();
        tube_x[11 +: 11] = 11'd79;
        frame();
        chk("pass1", 32'(score), 1);
        tube_x[11 +: 11] = 11'd77;
        frame();
        chk("nopass", 32'(score), 1);

        set_tube(2, 81, 100);
        tube_x[11 +: 11] = 11'd81;
        frame();
        tube_x[11 +: 11] = 11'd79;
        tube_x[22 +: 11] = 11'd79;
        frame();
        chk("pass2", 32'(score), 3);
        for (int k = 0; k < 127; k++) begin
            tube_x[11 +: 11] = 11'd81;
            tube_x[22 +: 11] = 11'd81;
            frame();
            tube_x[11 +: 11] = 11'd79;
            tube_x[22 +: 11] = 11'd79;
            frame();
        end
        chk("sat", 32'(score), 255);

        set_tube(1, 1100, 100);
        set_tube(2, 1100, 100);
        set_tube(0, 210, 200);
        frame();
        cyc(215, 60);
        chk("prio", 32'(rgb), 32'h00F);
        chk("hit_phase", 32'(phase), 2);
        cyc(1000, 767);
        chk("hit_coll", 32'(collision), 1);
        frame();
        frame();
        chk("coll_sticky", 32'(collision), 1);
        chk("hit_hold", 32'(phase), 2);
        chk("score_frz", 32'(score), 255);
        cyc(300, 10);
        chk("hit_tube", 32'(rgb), 32'h0D0);

`ifdef HIT_FLASH_EN
        cyc(220, 70);
        c0 = rgb;
        repeat (8) frame();
        cyc(220, 70);
        chk("flash", 32'(rgb), (c0 == 12'h00F) ? 32'hF00 : 32'h00F);
`else
        cyc(220, 70);
        c0 = rgb;
        chk("bird_hit_col", 32'(c0), 32'h00F);
`endif

        game_rst = 1'b1;
        bird_col = 1'b1;
        cyc(1000, 767);
        game_rst = 1'b0;
        bird_col = 1'b0;
        chk("grst_phase", 32'(phase), 0);
        chk("grst_coll", 32'(collision), 0);
        chk("grst_score", 32'(score), 0);

        bird_col = 1'b1;
        cyc(1000, 767);
        bird_col = 1'b0;
        chk("arm_col", 32'(phase), 2);
        cyc(1000, 767);
        chk("arm_coll", 32'(collision), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
